// File: rtl/fe_pkg.sv
// Shared constants and types for GF(2^255-19) field arithmetic.
package fe_pkg;

  localparam int unsigned FE_W  = 255;
  localparam int unsigned ACC_W = FE_W + 1;
  localparam int unsigned T_W   = FE_W + 2;
  localparam int unsigned CNT_W = 8;

  typedef logic [FE_W-1:0] fe_t;

  // p = 2^255 - 19
  localparam fe_t P = {FE_W{1'b1}} - fe_t'(18);

  localparam logic [CNT_W-1:0] TOP_BIT = CNT_W'(FE_W - 1);

  typedef struct packed {
    fe_t a;
    fe_t b;
  } fe_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

endpackage

// File: rtl/fe_fold.sv
// Two-stage 2^255 == 19 folder: maps any value below 2^257 to a congruent value below 2^255.
module fe_fold
  import fe_pkg::*;
(
  input  logic [T_W-1:0] x_i,
  output fe_t            y_o
);

  logic [ACC_W-1:0] t1;

  // The second fold cannot carry out: when t1[255] is set, the low bits are at most 56.
  always_comb begin
    t1  = {1'b0, x_i[FE_W-1:0]} + ACC_W'(x_i[T_W-1:FE_W]) * ACC_W'(19);
    y_o = t1[FE_W-1:0] + (t1[FE_W] ? fe_t'(19) : fe_t'(0));
  end

endmodule

// File: rtl/fe_mul.sv
// Bit-serial MSB-first modular multiplier over GF(2^255-19), fixed 256-cycle latency.
module fe_mul
  import fe_pkg::*;
(
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [FE_W-1:0] a_i,
  input  logic [FE_W-1:0] b_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [FE_W-1:0] out_o
);

  state_e           state_q, state_d;
  fe_pair_t         op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  fe_t              out_q, out_d;

  logic [T_W-1:0]   step_c;
  fe_t              fold_c;

  // One Horner step: 2*acc + B[i]*A, then folded back below 2^255.
  always_comb begin
    step_c = {acc_q, 1'b0} + (op_q.b[cnt_q] ? T_W'(op_q.a) : T_W'(0));
  end

  fe_fold u_fold (
    .x_i (step_c),
    .y_o (fold_c)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = '{a: a_i, b: b_i};
          acc_d   = '0;
          cnt_d   = TOP_BIT;
          ready_d = 1'b0;
          state_d = ST_MUL;
        end
      end

      ST_MUL: begin
        acc_d = {1'b0, fold_c};
        if (cnt_q == '0) begin
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // acc < 2^255 < 2p, so one conditional subtract yields the canonical value.
      ST_FINAL: begin
        out_d   = (acc_q >= {1'b0, P}) ? (acc_q[FE_W-1:0] - P) : acc_q[FE_W-1:0];
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign out_o   = out_q;

endmodule

// File: tb/tb_fe_mul.sv
// Scoreboard bench for fe_mul: directed vectors, back-to-back chain, busy-start and reset abort.
module tb_fe_mul;
  import fe_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic start;
  fe_t  a, b;
  logic ready, done;
  fe_t  out;

  fe_mul dut (
    .clock_i (clock),
    .reset_i (reset),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .ready_o (ready),
    .done_o  (done),
    .out_o   (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    fe_t exp;
    int  cyc;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  int  exp_done = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Independent reference: full 510-bit product reduced with a wide modulus.
  function automatic fe_t ref_mul(input fe_t x, input fe_t y);
    logic [511:0] pr;
    pr = 512'(x) * 512'(y);
    pr = pr % 512'(P);
    return fe_t'(pr);
  endfunction

  function automatic fe_t rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return fe_t'(r);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, 256 edges after accept.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_done observed=done expected=no_done cyc=%0d", cyc);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert (out === mon_e.exp) else begin
          failures++;
          $error("FAIL result observed=%h expected=%h", out, mon_e.exp);
        end
        checks++;
        assert (cyc === mon_e.cyc + 256) else begin
          failures++;
          $error("FAIL latency observed=%0d expected=%0d", cyc - mon_e.cyc, 256);
        end
        checks++;
        assert (ready === 1'b1) else begin
          failures++;
          $error("FAIL ready_in_done observed=%b expected=1", ready);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input fe_t x, input fe_t y, input fe_t e);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    assert (ready === 1'b1) else begin
      failures++;
      $error("FAIL issue_ready observed=%b expected=1", ready);
    end
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    sb.push_back('{exp: e, cyc: cyc});
    exp_done++;
    start = 1'b0;
    checks++;
    assert (ready === 1'b0) else begin
      failures++;
      $error("FAIL accept_ready observed=%b expected=0", ready);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      failures++;
      $error("FAIL done_timeout observed=%b expected=1", done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fe_t one, p128, ca[6], cb[6], prev;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    one   = fe_t'(1);
    p128  = one << 128;
    tick(); tick(); tick();
    reset = 1'b0;

    checks++;
    assert (ready === 1'b1) else begin failures++; $error("FAIL reset_ready observed=%b expected=1", ready); end
    checks++;
    assert (done === 1'b0) else begin failures++; $error("FAIL reset_done observed=%b expected=0", done); end
    checks++;
    assert (out === '0) else begin failures++; $error("FAIL reset_out observed=%h expected=0", out); end

    // Directed vectors with known results.
    issue(p128, p128, fe_t'(38));                     wait_done(); tick();
    issue({FE_W{1'b1}}, one, fe_t'(18));              wait_done(); tick();
    issue(one << 254, fe_t'(2), fe_t'(19));           wait_done(); tick();
    issue(p128 - one, p128 + one, fe_t'(37));         wait_done(); tick();
    issue((one << 250) - fe_t'(1997), fe_t'(36'hfffffffff) - fe_t'(17),
          255'h37ffffffffffffffffffffffffffffffffffffffffffffffffff833980008c57);
    wait_done(); tick();
    issue(255'h6483b328032df78f6abb1342dc54964127be97507e17c1b4cf481339f1fa20de,
          255'hb47d26181c9f63bb1405345faca4ffd0fe748b6652fa7d2decf0e2c865e988d,
          255'h7587e6935be3c0628e7fa76da3931343283adb49a03f048998eb0f9b51a209ef);
    wait_done(); tick();

    // Back-to-back chain: each new start lands in the previous done cycle.
    ca[0] = P;           cb[0] = rnd();
    ca[1] = P - one;     cb[1] = P - one;
    ca[2] = '0;          cb[2] = rnd();
    ca[3] = rnd();       cb[3] = rnd();
    ca[4] = rnd();       cb[4] = {FE_W{1'b1}};
    ca[5] = rnd();       cb[5] = rnd();
    issue(ca[0], cb[0], ref_mul(ca[0], cb[0]));
    for (int k = 1; k < 6; k++) begin
      wait_done();
      prev = ref_mul(ca[k-1], cb[k-1]);
      issue(ca[k], cb[k], ref_mul(ca[k], cb[k]));
      checks++;
      assert (out === prev) else begin
        failures++;
        $error("FAIL out_hold observed=%h expected=%h", out, prev);
      end
    end
    wait_done(); tick();

    // Start while busy must be ignored and not queued.
    ca[0] = rnd(); cb[0] = rnd();
    issue(ca[0], cb[0], ref_mul(ca[0], cb[0]));
    repeat (50) tick();
    a = rnd(); b = rnd(); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    tick(); tick();
    checks++;
    assert (ready === 1'b1) else begin failures++; $error("FAIL busy_start_queued observed=%b expected=1", ready); end

    // Reset in the middle of an operation aborts it.
    ca[1] = rnd(); cb[1] = rnd();
    issue(ca[1], cb[1], ref_mul(ca[1], cb[1]));
    repeat (99) tick();
    checks++;
    assert (ready === 1'b0) else begin failures++; $error("FAIL busy_ready observed=%b expected=0", ready); end
    reset = 1'b1;
    sb.delete();
    exp_done--;
    tick();
    reset = 1'b0;
    checks++;
    assert (ready === 1'b1) else begin failures++; $error("FAIL abort_ready observed=%b expected=1", ready); end
    checks++;
    assert (out === '0) else begin failures++; $error("FAIL abort_out observed=%h expected=0", out); end
    checks++;
    assert (done === 1'b0) else begin failures++; $error("FAIL abort_done observed=%b expected=0", done); end
    repeat (300) tick();

    // Recovery after abort.
    ca[2] = rnd(); cb[2] = rnd();
    issue(ca[2], cb[2], ref_mul(ca[2], cb[2]));
    wait_done(); tick(); tick();

    checks++;
    assert (done_cnt === exp_done) else begin
      failures++;
      $error("FAIL done_count observed=%0d expected=%0d", done_cnt, exp_done);
    end
    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("FAIL pending observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
